// File: rtl/pdm_mic_model_pkg.sv
// rtl/pdm_mic_model_pkg.sv - shared types and width helpers for the PDM microphone model
package pdm_mic_model_pkg;

    typedef enum logic [1:0] {
        EdgeNone = 2'd0,
        EdgeRise = 2'd1,
        EdgeFall = 2'd2
    } pdm_edge_e;

    function automatic int acc_width(input int sample_width);
        return sample_width + 2;
    endfunction

    // Feedback magnitude 2^(W-1) that the modulator subtracts or adds back.
    function automatic longint full_scale(input int sample_width);
        return longint'(1) << (sample_width - 1);
    endfunction

endpackage

// File: rtl/pdm_mic_model_fifo.sv
// rtl/pdm_mic_model_fifo.sv - PCM input queue, no bypass, pop ignored when empty
module pdm_mic_model_fifo #(
    parameter int Width = 16,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AddrW = $clog2(Depth);
    localparam logic [AddrW:0] DepthCnt = Depth[AddrW:0];

    logic [Width-1:0] mem [Depth];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [AddrW:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DepthCnt);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AddrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AddrW'(1);
            end
            count <= count + (AddrW + 1)'(do_push) - (AddrW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/pdm_sd_mod.sv
// rtl/pdm_sd_mod.sv - first-order sigma-delta modulator for one PDM channel
module pdm_sd_mod
    import pdm_mic_model_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             step,
    input  logic                             clear,
    input  logic signed [W-1:0]              x,
    output logic                             pdm_bit,
    output logic signed [acc_width(W)-1:0]   e
);
    localparam int AccW = acc_width(W);
    localparam logic signed [AccW-1:0] FullScale = AccW'(full_scale(W));

    logic signed [AccW-1:0] v;
    logic                   v_pos;

    assign v     = e + {{2{x[W-1]}}, x};
    assign v_pos = !v[AccW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e       <= '0;
            pdm_bit <= 1'b0;
        end else if (clear) begin
            e       <= '0;
            pdm_bit <= 1'b0;
        end else if (step) begin
            e       <= v_pos ? v - FullScale : v + FullScale;
            pdm_bit <= v_pos;
        end
    end

endmodule

// File: rtl/pdm_mic_model.sv
// rtl/pdm_mic_model.sv - PCM stream to single-line PDM microphone model, ch0 on rise, ch1 on fall
module pdm_mic_model
    import pdm_mic_model_pkg::*;
#(
    parameter int NumCh       = 1,
    parameter int SampleWidth = 16,
    parameter int Osr         = 64,
    parameter int FifoDepth   = 4,
    parameter int MaxSamples  = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic                         pdm_clk_i,
    input  logic [NumCh*SampleWidth-1:0] pcm_data_i,
    input  logic                         pcm_valid_i,
    output logic                         pcm_ready_o,
    output logic                         pdm_data_o,
    output logic                         underrun_o,
    output logic                         done_o,
    output logic [31:0]                  sample_cnt_o
);
    localparam int W     = SampleWidth;
    localparam int DataW = NumCh * W;
    localparam int AccW  = acc_width(W);
    localparam int OsrW  = $clog2(Osr);
    localparam logic [OsrW-1:0] OsrLast = OsrW'(Osr - 1);

    logic              pdm_sync1;
    logic              pdm_sync2;
    logic              pdm_dly;
    pdm_edge_e         pdm_edge;
    logic              active;
    logic              step_rise;
    logic              step_fall;
    logic              boundary;
    logic [OsrW-1:0]   osr_cnt;
    logic [DataW-1:0]  cur_sample;
    logic [DataW-1:0]  fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              out_sel;
    logic [1:0]        ch_bit;
    logic [2*AccW-1:0] unused_err;

    // Edge detection runs regardless of en_i so re-enabling never sees a stale edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pdm_sync1 <= 1'b0;
            pdm_sync2 <= 1'b0;
            pdm_dly   <= 1'b0;
        end else begin
            pdm_sync1 <= pdm_clk_i;
            pdm_sync2 <= pdm_sync1;
            pdm_dly   <= pdm_sync2;
        end
    end

    always_comb begin
        pdm_edge = EdgeNone;
        if (pdm_sync2 && !pdm_dly) begin
            pdm_edge = EdgeRise;
        end else if (!pdm_sync2 && pdm_dly) begin
            pdm_edge = EdgeFall;
        end
    end

    assign active      = en_i && !done_o;
    assign step_rise   = active && (pdm_edge == EdgeRise);
    assign step_fall   = active && (pdm_edge == EdgeFall) && (NumCh == 2);
    assign boundary    = step_rise && (osr_cnt == OsrLast);
    assign fifo_push   = pcm_valid_i && !fifo_full;
    assign fifo_pop    = boundary && !fifo_empty;
    assign pcm_ready_o = !fifo_full;
    assign pdm_data_o  = !done_o && (out_sel ? ch_bit[1] : ch_bit[0]);

    pdm_mic_model_fifo #(
        .Width (DataW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (fifo_push),
        .wdata (pcm_data_i),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    for (genvar c = 0; c < 2; c++) begin : g_ch
        if (c < NumCh) begin : g_mod
            pdm_sd_mod #(
                .W (W)
            ) u_mod (
                .clk     (clk_i),
                .rst_n   (rst_ni),
                .step    (c == 0 ? step_rise : step_fall),
                .clear   (!en_i),
                .x       (cur_sample[c*W +: W]),
                .pdm_bit (ch_bit[c]),
                .e       (unused_err[c*AccW +: AccW])
            );
        end else begin : g_off
            assign ch_bit[c]                  = 1'b0;
            assign unused_err[c*AccW +: AccW] = '0;
        end
    end

    // The step on a boundary rise still uses the old sample; the popped one applies from the next step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            osr_cnt      <= '0;
            sample_cnt_o <= '0;
            cur_sample   <= '0;
            underrun_o   <= 1'b0;
            done_o       <= 1'b0;
            out_sel      <= 1'b0;
        end else if (!en_i) begin
            osr_cnt      <= '0;
            sample_cnt_o <= '0;
            cur_sample   <= '0;
            underrun_o   <= 1'b0;
            done_o       <= 1'b0;
            out_sel      <= 1'b0;
        end else begin
            if (step_rise) begin
                out_sel <= 1'b0;
                osr_cnt <= boundary ? '0 : osr_cnt + OsrW'(1);
            end else if (step_fall) begin
                out_sel <= 1'b1;
            end
            if (boundary) begin
                sample_cnt_o <= sample_cnt_o + 32'd1;
                cur_sample   <= fifo_empty ? '0 : fifo_rdata;
                if (fifo_empty) begin
                    underrun_o <= 1'b1;
                end
                if ((MaxSamples != 0) && (sample_cnt_o + 32'd1 == 32'(MaxSamples))) begin
                    done_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_mic_model.sv
// tb/tb_pdm_mic_model.sv - table-driven and randomized checks of pdm_mic_model against a behavioural model
module tb_pdm_mic_model;
    localparam int W     = 16;
    localparam int Osr   = 4;
    localparam int Depth = 4;
    localparam int Half  = 32768;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        pdm_clk = 1'b0;
    logic [31:0] pcm_data2 = '0;
    logic        pcm_valid2 = 1'b0;
    logic        pcm_ready2, pdm_data2, underrun2, done2;
    logic [31:0] cnt2;
    logic [15:0] pcm_data1 = '0;
    logic        pcm_valid1 = 1'b0;
    logic        pcm_ready1, pdm_data1, underrun1, done1;
    logic [31:0] cnt1;

    always #5 clk = ~clk;

    pdm_mic_model #(.NumCh(2), .SampleWidth(W), .Osr(Osr), .FifoDepth(Depth), .MaxSamples(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pdm_clk_i(pdm_clk),
        .pcm_data_i(pcm_data2), .pcm_valid_i(pcm_valid2), .pcm_ready_o(pcm_ready2),
        .pdm_data_o(pdm_data2), .underrun_o(underrun2), .done_o(done2), .sample_cnt_o(cnt2)
    );

    pdm_mic_model #(.NumCh(1), .SampleWidth(W), .Osr(Osr), .FifoDepth(Depth), .MaxSamples(3)) dut_lim (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pdm_clk_i(pdm_clk),
        .pcm_data_i(pcm_data1), .pcm_valid_i(pcm_valid1), .pcm_ready_o(pcm_ready1),
        .pdm_data_o(pdm_data1), .underrun_o(underrun1), .done_o(done1), .sample_cnt_o(cnt1)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          m_e[2];
    int          m_x[2];
    int          m_osr;
    int          m_cnt;
    bit          m_under;
    bit          m_bit;
    logic [31:0] m_q[$];

    typedef struct {
        logic signed [15:0] x0;
        logic signed [15:0] x1;
        int                 ones0;
        int                 ones1;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp);
        n_checks++;
        if (act > exp + 1 || act + 1 < exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- 1", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_e = '{0, 0};
        m_x = '{0, 0};
        m_osr = 0;
        m_cnt = 0;
        m_under = 1'b0;
        m_bit = 1'b0;
    endfunction

    function automatic bit sd_step(input int ch);
        int v;
        bit b;
        v = m_e[ch] + m_x[ch];
        b = (v >= 0);
        m_e[ch] = b ? v - Half : v + Half;
        return b;
    endfunction

    function automatic void model_rise();
        logic [31:0] d;
        m_bit = sd_step(0);
        m_osr++;
        if (m_osr == Osr) begin
            m_osr = 0;
            m_cnt++;
            if (m_q.size() > 0) begin
                d = m_q.pop_front();
                m_x[0] = int'($signed(d[15:0]));
                m_x[1] = int'($signed(d[31:16]));
            end else begin
                m_under = 1'b1;
                m_x = '{0, 0};
            end
        end
    endfunction

    task automatic drive_pdm(input logic level);
        @(negedge clk);
        pdm_clk = level;
        repeat (4) @(negedge clk);
    endtask

    task automatic rise();
        drive_pdm(1'b1);
        model_rise();
        check("rise_bit", pdm_data2, m_bit);
        check("sample_cnt", cnt2, m_cnt);
        check("underrun", underrun2, m_under);
    endtask

    task automatic fall();
        drive_pdm(1'b0);
        m_bit = sd_step(1);
        check("fall_bit", pdm_data2, m_bit);
    endtask

    task automatic cycle();
        rise();
        fall();
    endtask

    task automatic push2(input logic [31:0] d);
        @(negedge clk);
        check("pcm_ready", pcm_ready2, m_q.size() < Depth);
        pcm_data2 = d;
        pcm_valid2 = 1'b1;
        @(negedge clk);
        pcm_valid2 = 1'b0;
        if (m_q.size() < Depth) m_q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pdm_clk = 1'b0;
        pcm_valid1 = 1'b0;
        pcm_valid2 = 1'b0;
        en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        model_clear();
        @(negedge clk);
    endtask

    task automatic en_pulse();
        @(negedge clk);
        en = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones0, ones1;
        vecs[0] = '{16'h0000, 16'h0000, 32, 32};
        vecs[1] = '{16'h8000, 16'h8000, 0, 0};
        vecs[2] = '{16'h4000, 16'hC000, 48, 16};
        vecs[3] = '{16'h7FFF, 16'h0000, 64, 32};
        vecs[4] = '{16'hC000, 16'h2000, 16, 40};
        vecs[5] = '{16'h2000, 16'h8000, 40, 0};
        model_clear();

        repeat (3) @(negedge clk);
        check("rst_ready", pcm_ready2, 1);
        check("rst_pdm", pdm_data2, 0);
        check("rst_underrun", underrun2, 0);
        check("rst_done", done2, 0);
        check("rst_cnt", cnt2, 0);
        check("rst_ready_lim", pcm_ready1, 1);
        check("rst_done_lim", done1, 0);
        rst_n = 1'b1;

        do_reset();
        rise(); check("first_rise_bit", pdm_data2, 1);
        fall(); check("first_fall_bit", pdm_data2, 1);
        rise(); check("second_rise_bit", pdm_data2, 0);
        fall(); check("second_fall_bit", pdm_data2, 0);

        foreach (vecs[i]) begin
            do_reset();
            repeat (Depth) push2({vecs[i].x1, vecs[i].x0});
            repeat (Osr) cycle();
            ones0 = 0;
            ones1 = 0;
            repeat (64) begin
                if (m_q.size() < Depth) push2({vecs[i].x1, vecs[i].x0});
                rise();
                ones0 += int'(pdm_data2);
                fall();
                ones1 += int'(pdm_data2);
            end
            check_near("density_ch0", ones0, vecs[i].ones0);
            check_near("density_ch1", ones1, vecs[i].ones1);
        end

        do_reset();
        push2(32'hC000_4000);
        repeat (3) cycle();
        rise();
        check("pop_cnt", cnt2, 1);
        check("pop_underrun", underrun2, 0);
        fall();
        repeat (3) cycle();
        rise();
        check("underrun_cnt", cnt2, 2);
        check("underrun_flag", underrun2, 1);
        fall();
        repeat (4) cycle();

        do_reset();
        @(negedge clk);
        pcm_data1 = 16'h7FFF;
        pcm_valid1 = 1'b1;
        repeat (3) @(negedge clk);
        check("lim_ready_before_full", pcm_ready1, 1);
        @(negedge clk);
        check("lim_ready_full", pcm_ready1, 0);
        for (int k = 1; k <= 12; k++) begin
            drive_pdm(1'b1);
            if (k == 11) begin
                check("lim_done_early", done1, 0);
                check("lim_cnt_early", cnt1, 2);
                check("lim_bit_early", pdm_data1, 1);
            end
            if (k == 12) begin
                check("lim_done", done1, 1);
                check("lim_cnt", cnt1, 3);
                check("lim_bit_forced", pdm_data1, 0);
            end
            drive_pdm(1'b0);
        end
        repeat (2) begin
            drive_pdm(1'b1);
            check("lim_bit_after_done", pdm_data1, 0);
            check("lim_cnt_after_done", cnt1, 3);
            drive_pdm(1'b0);
        end
        check("lim_done_sticky", done1, 1);
        check("lim_ready_kept_full", pcm_ready1, 0);
        pcm_valid1 = 1'b0;

        do_reset();
        push2(32'h2000_2000);
        push2(32'h1000_1000);
        repeat (4) cycle();
        @(negedge clk);
        en = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("dis_cnt", cnt2, 0);
        check("dis_underrun", underrun2, 0);
        check("dis_pdm", pdm_data2, 0);
        push2(32'h3000_3000);
        drive_pdm(1'b1);
        drive_pdm(1'b0);
        check("dis_cnt_edges", cnt2, 0);
        check("dis_pdm_edges", pdm_data2, 0);
        @(negedge clk);
        en = 1'b1;
        rise();
        check("reenable_first_bit", pdm_data2, 1);
        fall();
        repeat (3) cycle();
        check("reenable_fifo_kept", underrun2, 0);
        repeat (4) cycle();

        do_reset();
        repeat (4) push2(32'h1234_0F0F);
        repeat (5) cycle();
        push2(32'h0001_FFFF);
        @(negedge clk);
        check("full_before_reset", pcm_ready2, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_ready", pcm_ready2, 1);
        check("async_cnt", cnt2, 0);
        check("async_pdm", pdm_data2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        model_clear();
        repeat (4) cycle();
        check("reset_emptied_fifo", underrun2, 1);

        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) != 0) push2($urandom);
            rise();
            if ($urandom_range(0, 3) == 0) push2($urandom);
            fall();
            if ($urandom_range(0, 49) == 0) en_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
